// File: rtl/mult_bcd_seq_if.sv
// mult_bcd_seq_if: handshake bundle for the sequential multiply / BCD path.
//   in_valid / in_ready : operand pair handshake (A, B)
//   out_valid / out_ready : result handshake (product, bcd)
//   busy : controller is computing (multiply or conversion phase)
// master = operand source / result consumer, slave = mult_bcd_seq.
interface mult_bcd_seq_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      A;
    logic [WIDTH-1:0]      B;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*WIDTH-1:0]    product;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, product, bcd, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, product, bcd, busy
    );
endinterface

// File: rtl/mult_bcd_seq.sv
// mult_bcd_seq: sequential shift-and-add multiplier followed by an iterative
// double-dabble binary-to-BCD converter, feeding seven-segment drivers.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_bcd_seq_if slave modport
//           in_valid/in_ready/A/B  operand handshake
//           out_valid/out_ready/product/bcd  result handshake, held in DONE
//           busy  high while multiplying or converting
// Latency: 3*WIDTH edges from accept to out_valid (WIDTH multiply steps,
// 2*WIDTH conversion steps). bcd[3:0] = units, [7:4] = tens, [11:8] = hundreds.
module mult_bcd_seq #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_bcd_seq_if.slave   bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = (PW > 2) ? $clog2(PW) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(PW - 1);

    typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    bin_sh;
    logic [BW-1:0]    bcd_sh;
    logic [PW-1:0]    product_reg;
    logic [BW-1:0]    bcd_reg;

    logic [WIDTH-1:0]  b_shifted;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     acc_sum;
    logic [BW+PW-1:0]  dd_shifted;

    // Double-dabble correction: any digit >= 5 gets +3 so that the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        b_shifted  = b_reg >> cnt;
        partial    = b_shifted[0] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
        acc_sum    = acc + partial;
        dd_shifted = {dabble_adjust(bcd_sh), bin_sh} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)     state_next = MUL;
            MUL:     if (cnt == MUL_LAST)  state_next = CONV;
            CONV:    if (cnt == CONV_LAST) state_next = DONE;
            DONE:    if (bus.out_ready)    state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            bin_sh      <= '0;
            bcd_sh      <= '0;
            product_reg <= '0;
            bcd_reg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.A;
                        b_reg <= bus.B;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_sum;
                    if (cnt == MUL_LAST) begin
                        // final partial product goes straight into the converter
                        bin_sh <= acc_sum;
                        bcd_sh <= '0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONV: begin
                    bcd_sh <= dd_shifted[PW +: BW];
                    bin_sh <= dd_shifted[PW-1:0];
                    if (cnt == CONV_LAST) begin
                        product_reg <= acc;
                        bcd_reg     <= dd_shifted[PW +: BW];
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == MUL) || (state == CONV);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = product_reg;
    assign bus.bcd       = bcd_reg;
endmodule

// File: tb/tb_mult_bcd_seq.sv
// tb_mult_bcd_seq: scoreboard bench for mult_bcd_seq. Accepted operand pairs
// push a reference product/BCD into a queue; consumed results pop and compare.
module tb_mult_bcd_seq;
    localparam int WIDTH  = 4;
    localparam int DIGITS = 3;

    typedef struct {
        logic [7:0]  p;
        logic [11:0] b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;

    mult_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    mult_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Scoreboard monitor: samples on the falling edge, i.e. the values the
    // next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                mon_e.p = {4'b0, bus.A} * {4'b0, bus.B};
                mon_e.b = to_bcd(int'(mon_e.p));
                sb.push_back(mon_e);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_product", 32'(bus.product), 32'(mon_e.p));
                    chk("sb_bcd", 32'(bus.bcd), 32'(mon_e.b));
                end
            end
        end
    end

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!bus.out_valid) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after_done", 32'(bus.in_ready), 32'd1);
        chk("out_valid_after_done", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int hold, input bit disturb);
        logic [7:0]  ep;
        logic [11:0] eb;
        ep = {4'b0, a} * {4'b0, b};
        eb = to_bcd(int'(ep));
        @(posedge clk); #1;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("busy_e0", 32'(bus.busy), 32'd1);
        chk("in_ready_e0", 32'(bus.in_ready), 32'd0);
        if (disturb) begin
            bus.A        = ~a;
            bus.B        = ~b;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            wait_done("op", 10);
        end else begin
            wait_done("op", 12);
        end
        chk("product", 32'(bus.product), 32'(ep));
        chk("bcd", 32'(bus.bcd), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_product", 32'(bus.product), 32'(ep));
            chk("hold_bcd", 32'(bus.bcd), 32'(eb));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        end
        consume();
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_bcd", 32'(bus.bcd), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        run_op(4'd0, 4'd0, 0, 1'b0);
        run_op(4'd15, 4'd15, 0, 1'b0);
        run_op(4'd7, 4'd9, 0, 1'b1);
        run_op(4'd9, 4'd12, 5, 1'b0);

        // back-to-back with in_valid held high
        @(posedge clk); #1;
        bus.A        = 4'd3;
        bus.B        = 4'd5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.A = 4'd10;
        bus.B = 4'd10;
        chk("b2b_busy_e0", 32'(bus.busy), 32'd1);
        wait_done("b2b1", 12);
        chk("b2b1_bcd", 32'(bus.bcd), 32'h015);
        chk("b2b1_in_ready", 32'(bus.in_ready), 32'd0);
        consume();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("b2b2_accept_busy", 32'(bus.busy), 32'd1);
        wait_done("b2b2", 12);
        chk("b2b2_product", 32'(bus.product), 32'h64);
        chk("b2b2_bcd", 32'(bus.bcd), 32'h100);
        consume();

        // reset during conversion
        @(posedge clk); #1;
        bus.A        = 4'd13;
        bus.B        = 4'd11;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_product", 32'(bus.product), 32'd0);
        chk("mid_rst_bcd", 32'(bus.bcd), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(4'd2, 4'd3, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
